ifetch_queue: RTL and testbench

- Parametrised successor to the single-register fetch stage.
- Generates sequential fetch addresses and issues them to instruction memory through a request/grant port.
- Accepts in-order responses and buffers up to DEPTH address/instruction pairs, presenting them to decode through a valid/stall handshake.
- Branch redirects flush the buffer and discard stale in-flight responses, so decode never sees wrong-path instructions.

---
 rtl/ifetch_queue.sv | 101 ++++++++++
 tb/tb_ifetch_queue.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/ifetch_queue.sv
// Instruction fetch queue: issues sequential fetches, buffers in-order responses,
// and flushes wrong-path work on branch redirects. Define IFETCH_BYPASS_EN for a zero-latency response-to-decode path.
module ifetch_queue #(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              branch_i,
  input  logic [ADDR_W-1:0] baddr_i,
  output logic              mreq_o,
  output logic [ADDR_W-1:0] maddr_o,
  input  logic              mgnt_i,
  input  logic              mresp_v_i,
  input  logic [INST_W-1:0] mresp_data_i,
  output logic              v_o,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] addr_o,
  input  logic              stall_i
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  // Handshakes: a memory request transfers when mreq_o & mgnt_i; a response
  // transfers whenever mresp_v_i; decode takes the head when v_o & ~stall_i.

  logic [ADDR_W-1:0] pc;
  logic [PW-1:0]     wptr, fptr, rptr, drop_cnt;
  logic              init_r;
  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];

  logic [PW-1:0] alloc, pend, drop_next;
  logic [PW:0]   occupancy;
  logic          grant, resp_drop, resp_fill, bypass, head_v, pop;

  always_comb begin
    alloc     = wptr - rptr;
    pend      = wptr - fptr;
    // Stale in-flight responses still occupy memory-side slots, so they count too.
    occupancy = {1'b0, alloc} + {1'b0, drop_cnt};
    mreq_o    = init_r & ~branch_i & (occupancy < (PW+1)'(DEPTH));
    maddr_o   = pc;
    grant     = mreq_o & mgnt_i;
    resp_drop = mresp_v_i & (drop_cnt != '0);
    resp_fill = mresp_v_i & (drop_cnt == '0) & (pend != '0);
`ifdef IFETCH_BYPASS_EN
    bypass    = resp_fill & (fptr == rptr);
`else
    bypass    = 1'b0;
`endif
    head_v    = (fptr != rptr) | bypass;
    v_o       = head_v & ~branch_i;
    pop       = v_o & ~stall_i;
    inst_o    = '0;
    addr_o    = '0;
    if (v_o) begin
      addr_o = addr_mem[rptr[AW-1:0]];
      inst_o = bypass ? mresp_data_i : inst_mem[rptr[AW-1:0]];
    end
    // Unfilled current-path entries become responses to discard after a redirect.
    drop_next = drop_cnt + pend - {{(PW-1){1'b0}}, resp_drop | resp_fill};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc       <= RESET_PC;
      wptr     <= '0;
      fptr     <= '0;
      rptr     <= '0;
      drop_cnt <= '0;
      init_r   <= 1'b0;
    end else begin
      init_r <= 1'b1;
      if (branch_i) begin
        pc       <= baddr_i;
        wptr     <= '0;
        fptr     <= '0;
        rptr     <= '0;
        drop_cnt <= drop_next;
      end else begin
        if (grant) begin
          wptr <= wptr + 1'b1;
          pc   <= pc + 1'b1;
        end
        if (resp_drop) drop_cnt <= drop_cnt - 1'b1;
        if (resp_fill) fptr <= fptr + 1'b1;
        if (pop)       rptr <= rptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (grant)                 addr_mem[wptr[AW-1:0]] <= pc;
    if (resp_fill & ~branch_i) inst_mem[fptr[AW-1:0]] <= mresp_data_i;
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Randomised bench for ifetch_queue: a transaction-level model predicts each cycle's
// outputs into a queue that an independent monitor drains and compares.
module tb_ifetch_queue;
  localparam int ADDR_W = 8;
  localparam int INST_W = 32;
  localparam int DEPTH  = 4;
  localparam logic [ADDR_W-1:0] RESET_PC = 8'hFE;
  localparam int NCYC = 3000;

  logic              clk, rst;
  logic              branch_i, mgnt_i, mresp_v_i, stall_i;
  logic [ADDR_W-1:0] baddr_i, maddr_o, addr_o;
  logic [INST_W-1:0] mresp_data_i, inst_o;
  logic              mreq_o, v_o;

  ifetch_queue #(.ADDR_W(ADDR_W), .INST_W(INST_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .branch_i(branch_i), .baddr_i(baddr_i),
    .mreq_o(mreq_o), .maddr_o(maddr_o), .mgnt_i(mgnt_i),
    .mresp_v_i(mresp_v_i), .mresp_data_i(mresp_data_i),
    .v_o(v_o), .inst_o(inst_o), .addr_o(addr_o), .stall_i(stall_i)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [ADDR_W-1:0] addr; logic [INST_W-1:0] data; bit filled; } ent_t;
  typedef struct { int epoch; logic [INST_W-1:0] data; } mem_t;
  typedef struct { logic mreq; logic [ADDR_W-1:0] maddr; logic v;
                   logic [ADDR_W-1:0] addr; logic [INST_W-1:0] inst; } exp_t;

  ent_t cur_q[$];   // current-path fetches granted and not yet consumed by decode
  mem_t mem_q[$];   // responses the memory still owes, in order
  exp_t exp_q[$];   // per-cycle predicted outputs
  int   checks, errors, cyc, cur_epoch;
  logic [ADDR_W-1:0] model_pc;
  bit   model_init;

  function automatic int stale_cnt();
    int n = 0;
    foreach (mem_q[i]) if (mem_q[i].epoch != cur_epoch) n++;
    return n;
  endfunction

  function automatic int filled_cnt();
    int n = 0;
    for (int i = 0; i < cur_q.size(); i++) begin
      if (!cur_q[i].filled) break;
      n++;
    end
    return n;
  endfunction

  task automatic model_reset();
    cur_q.delete();
    mem_q.delete();
    model_pc   = RESET_PC;
    model_init = 1'b0;
    cur_epoch++;
  endtask

  // driver: apply one cycle of stimulus, predict outputs, advance the model
  task automatic drive_cycle(input bit br, input logic [ADDR_W-1:0] ba, input bit gnt,
                             input bit rv, input bit stl);
    exp_t e;
    int   nf;
    bit   mreq, resp_cur, byp, pop;
    logic [INST_W-1:0] d;
    branch_i  = br;
    baddr_i   = ba;
    mgnt_i    = gnt;
    mresp_v_i = rv;
    stall_i   = stl;
    if (rv) mresp_data_i = mem_q[0].data;
    else    mresp_data_i = $urandom;
    if (!rst) begin
      e = '{mreq: 1'b0, maddr: RESET_PC, v: 1'b0, addr: '0, inst: '0};
      exp_q.push_back(e);
      return;
    end
    nf       = filled_cnt();
    mreq     = model_init && !br && (cur_q.size() + stale_cnt() < DEPTH);
    resp_cur = rv && (mem_q[0].epoch == cur_epoch);
    byp      = 1'b0;
`ifdef IFETCH_BYPASS_EN
    byp      = !br && (nf == 0) && resp_cur;
`endif
    e.mreq  = mreq;
    e.maddr = model_pc;
    e.v     = !br && (nf > 0 || byp);
    e.addr  = e.v ? cur_q[0].addr : '0;
    e.inst  = e.v ? cur_q[0].data : '0;
    exp_q.push_back(e);
    pop = e.v && !stl;
    model_init = 1'b1;
    if (rv) void'(mem_q.pop_front());
    if (br) begin
      cur_q.delete();
      cur_epoch++;
      model_pc = ba;
    end else begin
      if (resp_cur) begin
        assert (nf < cur_q.size()) else $error("response with nothing pending");
        cur_q[nf].filled = 1'b1;
      end
      if (pop) void'(cur_q.pop_front());
      if (mreq && gnt) begin
        d = $urandom;
        cur_q.push_back('{addr: model_pc, data: d, filled: 1'b0});
        mem_q.push_back('{epoch: cur_epoch, data: d});
        model_pc = model_pc + 1'b1;
      end
    end
  endtask

  // scoreboard / monitor
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("mreq_o",  32'(mreq_o),  32'(e.mreq));
      check("maddr_o", 32'(maddr_o), 32'(e.maddr));
      check("v_o",     32'(v_o),     32'(e.v));
      check("addr_o",  32'(addr_o),  32'(e.addr));
      check("inst_o",  32'(inst_o),  32'(e.inst));
    end
  end

  // stimulus
  initial begin
    int stall_left;
    bit br, gnt, rv, stl;
    checks = 0; errors = 0; cyc = 0; cur_epoch = 0; stall_left = 0;
    rst = 1'b0;
    branch_i = 0; baddr_i = '0; mgnt_i = 0; mresp_v_i = 0; mresp_data_i = '0; stall_i = 0;
    model_reset();
    repeat (3) begin
      @(negedge clk);
      drive_cycle(0, '0, 0, 0, 0);
    end
    for (cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      if (cyc == 0 || cyc == 1503) rst = 1'b1;
      if (cyc == 1500) begin
        rst = 1'b0;
        model_reset();
      end
      if (cyc < 40) begin
        br = 0; gnt = 1; rv = (mem_q.size() > 0); stl = 0;
      end else if (cyc < 46) begin
        br = 0; gnt = 1; rv = (mem_q.size() > 0); stl = 1;
      end else begin
        br  = ($urandom_range(0, 15) == 0);
        gnt = ($urandom_range(0, 3) != 0);
        rv  = (mem_q.size() > 0) && ($urandom_range(0, 1) == 1);
        if (stall_left > 0) begin
          stl = 1; stall_left--;
        end else if ($urandom_range(0, 19) == 0) begin
          stl = 1; stall_left = $urandom_range(1, 8);
        end else begin
          stl = ($urandom_range(0, 4) == 0);
        end
      end
      drive_cycle(br, ADDR_W'($urandom), gnt, rv, stl);
    end
    @(negedge clk);
    #2;
    check("exp_q drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
